// File: rtl/vectored_event_controller.sv
// Vectored event controller: synchronises raw event requests, latches them as
// pending, and presents the most urgent serviceable one (highest index that is
// enabled and at or above the priority floor) until it is acknowledged.
module vectored_event_controller #(
    parameter int unsigned NUM_INPUTS = 6,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  sysclk,
    input  logic                  sysreset,
    input  logic [NUM_INPUTS-1:0] event_signals,
    input  logic                  cfg_load,
    input  logic [1:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  event_ack,
    output logic                  event_valid,
    output logic [DATA_WIDTH-1:0] priority_out,
    output logic [NUM_INPUTS-1:0] overrun
);

    localparam int unsigned EXT_W   = (NUM_INPUTS > DATA_WIDTH) ? NUM_INPUTS : DATA_WIDTH;
    localparam int unsigned FLOOR_W = 5;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_EDGE    = 2'd1;
    localparam logic [1:0] ADDR_FLOOR   = 2'd2;
    localparam logic [1:0] ADDR_OVR_CLR = 2'd3;

    logic [NUM_INPUTS-1:0] ev_q;
    logic [NUM_INPUTS-1:0] ev_prev;
    logic [NUM_INPUTS-1:0] pending;
    logic [NUM_INPUTS-1:0] mask;
    logic [NUM_INPUTS-1:0] edge_mode;
    logic [FLOOR_W-1:0]    floor_lvl;

    logic [EXT_W-1:0]      data_ext;
    logic [NUM_INPUTS-1:0] cfg_bits;
    logic [FLOOR_W-1:0]    cfg_floor;
    logic                  unused_data_bits;

    logic [NUM_INPUTS-1:0] req;
    logic [NUM_INPUTS-1:0] arrival;
    logic [NUM_INPUTS-1:0] clr;
    logic [NUM_INPUTS-1:0] pending_nxt;
    logic [NUM_INPUTS-1:0] ovr_set;
    logic [NUM_INPUTS-1:0] ovr_w1c;
    logic [NUM_INPUTS-1:0] overrun_nxt;
    logic [NUM_INPUTS-1:0] svc;
    logic                  sel_valid;
    logic [FLOOR_W-1:0]    sel_idx;

    // Zero-extend write data so narrow DATA_WIDTH still yields a full event-wide field
    assign data_ext         = EXT_W'(data_in);
    assign cfg_bits         = data_ext[NUM_INPUTS-1:0];
    assign cfg_floor        = data_ext[FLOOR_W-1:0];
    assign unused_data_bits = ^data_ext;

    // Request decode, pending/overrun next state and most-urgent selection
    always_comb begin
        req         = '0;
        arrival     = '0;
        clr         = '0;
        pending_nxt = '0;
        ovr_set     = '0;
        ovr_w1c     = '0;
        overrun_nxt = '0;
        svc         = '0;
        sel_valid   = 1'b0;
        sel_idx     = '0;

        // Edge-mode bits only request on a rising sample; level bits request while high
        req     = ev_q & ~(edge_mode & ev_prev);
        // A fresh rising sample; a level input merely staying high is not a new arrival
        arrival = ev_q & ~ev_prev;

        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            clr[i] = event_ack && event_valid && (priority_out == DATA_WIDTH'(i));
        end

        // Set wins over a same-cycle clear
        pending_nxt = (pending & ~clr) | req;

        ovr_set = arrival & pending & ~clr;
        if (cfg_load && (cfg_addr == ADDR_OVR_CLR)) begin
            ovr_w1c = cfg_bits;
        end
        overrun_nxt = (overrun & ~ovr_w1c) | ovr_set;

        // Select from pending with this cycle's ack already removed so an acked
        // event is never presented twice; new arrivals follow one cycle later
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            svc[i] = pending[i] && !clr[i] && mask[i] && (FLOOR_W'(i) >= floor_lvl);
            if (svc[i]) begin
                sel_valid = 1'b1;
                sel_idx   = FLOOR_W'(i);
            end
        end
    end

    // State, configuration and registered outputs
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            ev_q         <= '0;
            ev_prev      <= '0;
            pending      <= '0;
            overrun      <= '0;
            mask         <= '1;
            edge_mode    <= '0;
            floor_lvl    <= '0;
            event_valid  <= 1'b0;
            priority_out <= '0;
        end else begin
            ev_q         <= event_signals;
            ev_prev      <= ev_q;
            pending      <= pending_nxt;
            overrun      <= overrun_nxt;
            event_valid  <= sel_valid;
            priority_out <= sel_valid ? DATA_WIDTH'(sel_idx) : '0;
            if (cfg_load) begin
                case (cfg_addr)
                    ADDR_MASK:  mask      <= cfg_bits;
                    ADDR_EDGE:  edge_mode <= cfg_bits;
                    ADDR_FLOOR: floor_lvl <= cfg_floor;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vectored_event_controller.sv
// Directed, table-driven bench for vectored_event_controller (default parameters).
module tb_vectored_event_controller;

    localparam int unsigned N  = 6;
    localparam int unsigned DW = 16;

    logic          sysclk = 1'b0;
    logic          sysreset;
    logic [N-1:0]  event_signals;
    logic          cfg_load;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] data_in;
    logic          event_ack;
    logic          event_valid;
    logic [DW-1:0] priority_out;
    logic [N-1:0]  overrun;

    vectored_event_controller #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .event_signals (event_signals),
        .cfg_load      (cfg_load),
        .cfg_addr      (cfg_addr),
        .data_in       (data_in),
        .event_ack     (event_ack),
        .event_valid   (event_valid),
        .priority_out  (priority_out),
        .overrun       (overrun)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic          rst;
        logic [N-1:0]  ev;
        logic          ld;
        logic [1:0]    addr;
        logic [DW-1:0] data;
        logic          ack;
        logic          chk;
        logic          exp_valid;
        logic [DW-1:0] exp_prio;
        logic [N-1:0]  exp_ovr;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Append one stimulus cycle; outputs are checked after its clock edge when chk is set
    task automatic add(input logic rst, input logic [N-1:0] ev, input logic ld,
                       input logic [1:0] addr, input logic [DW-1:0] data, input logic ack,
                       input logic chk, input logic v, input logic [DW-1:0] p,
                       input logic [N-1:0] o);
        vec_t t;
        t.rst = rst; t.ev = ev; t.ld = ld; t.addr = addr; t.data = data; t.ack = ack;
        t.chk = chk; t.exp_valid = v; t.exp_prio = p; t.exp_ovr = o;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic chk, input logic v, input logic [DW-1:0] p,
                        input logic [N-1:0] o);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b0, chk, v, p, o);
    endtask

    task automatic cfg(input logic [1:0] addr, input logic [DW-1:0] data, input logic chk,
                       input logic v, input logic [DW-1:0] p, input logic [N-1:0] o);
        add(1'b0, '0, 1'b1, addr, data, 1'b0, chk, v, p, o);
    endtask

    task automatic check(input string name, input int idx, input logic v,
                         input logic [DW-1:0] p, input logic [N-1:0] o);
        n_total += 3;
        if (event_valid === v) n_pass++;
        else $display("FAIL %s[%0d] event_valid got %b want %b", name, idx, event_valid, v);
        if (priority_out === p) n_pass++;
        else $display("FAIL %s[%0d] priority_out got %0d want %0d", name, idx, priority_out, p);
        if (overrun === o) n_pass++;
        else $display("FAIL %s[%0d] overrun got %b want %b", name, idx, overrun, o);
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] ev, input logic ld,
                         input logic [1:0] addr, input logic [DW-1:0] data, input logic ack);
        @(negedge sysclk);
        sysreset = rst; event_signals = ev; cfg_load = ld; cfg_addr = addr;
        data_in = data; event_ack = ack;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        sysreset = 1'b1; event_signals = '0; cfg_load = 1'b0; cfg_addr = '0;
        data_in = '0; event_ack = 1'b0;

        // Reset state
        add(1'b1, '0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 16'd0, 6'b0);
        // Single level pulse on bit 2, two-cycle latency, ack clears
        add(1'b0, 6'b000100, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd2, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        // Priority order 5 -> 3 -> 1
        add(1'b0, 6'b101010, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd5, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b1, 16'd3, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b1, 16'd1, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        // Mask hides bit 5, floor hides bit 1; unmasking reveals bit 5
        cfg(2'd0, 16'h001F, 1'b0, 1'b0, 16'd0, 6'b0);
        cfg(2'd2, 16'd2, 1'b0, 1'b0, 16'd0, 6'b0);
        add(1'b0, 6'b100010, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 16'd0, 6'b0);
        idle(1'b0, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        cfg(2'd0, 16'h003F, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd5, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        cfg(2'd2, 16'd0, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd1, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        // Edge mode on bit 0: long high gives one pend, second rise gives overrun
        cfg(2'd1, 16'h0001, 1'b0, 1'b0, 16'd0, 6'b0);
        for (int i = 0; i < 10; i++)
            add(1'b0, 6'b000001, 1'b0, 2'd0, '0, 1'b0, (i >= 2), (i >= 2), 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd0, 6'b0);
        add(1'b0, 6'b000001, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1, 16'd0, 6'b0);
        add(1'b0, 6'b000001, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1, 16'd0, 6'b000001);
        idle(1'b1, 1'b1, 16'd0, 6'b000001);
        cfg(2'd3, 16'h0001, 1'b1, 1'b1, 16'd0, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        // Edge-mode bit 4 rises in the acked cycle: stays pending, one gap cycle
        cfg(2'd1, 16'h0011, 1'b0, 1'b0, 16'd0, 6'b0);
        add(1'b0, 6'b010000, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 16'd0, 6'b0);
        idle(1'b0, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd4, 6'b0);
        add(1'b0, 6'b010000, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1, 16'd4, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd4, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        // Floor beyond range blocks everything; ack while idle is ignored
        cfg(2'd2, 16'd6, 1'b0, 1'b0, 16'd0, 6'b0);
        add(1'b0, 6'b001000, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 16'd0, 6'b0);
        idle(1'b0, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        cfg(2'd2, 16'd0, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd3, 6'b0);
        // Build up pending and overrun, then reset mid-operation
        add(1'b0, 6'b101100, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1, 16'd3, 6'b0);
        idle(1'b1, 1'b1, 16'd3, 6'b001000);
        cfg(2'd0, 16'h0000, 1'b1, 1'b1, 16'd5, 6'b001000);
        add(1'b1, 6'b111111, 1'b1, 2'd2, 16'd3, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        add(1'b0, 6'b000001, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b0, 16'd0, 6'b0);
        idle(1'b1, 1'b1, 16'd0, 6'b0);
        add(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, 16'd0, 6'b0);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].ev, vecs[k].ld, vecs[k].addr, vecs[k].data, vecs[k].ack);
            if (vecs[k].chk) check("vec", k, vecs[k].exp_valid, vecs[k].exp_prio, vecs[k].exp_ovr);
        end

        // Event held high through reset re-pends with normal latency afterwards
        drive(1'b1, 6'b000100, 1'b0, 2'd0, '0, 1'b0);
        drive(1'b1, 6'b000100, 1'b0, 2'd0, '0, 1'b0);
        check("hold_rst", 0, 1'b0, 16'd0, 6'b0);
        drive(1'b0, 6'b000100, 1'b0, 2'd0, '0, 1'b0);
        check("hold_rst", 1, 1'b0, 16'd0, 6'b0);
        drive(1'b0, 6'b000000, 1'b0, 2'd0, '0, 1'b0);
        check("hold_rst", 2, 1'b0, 16'd0, 6'b0);
        drive(1'b0, 6'b000000, 1'b0, 2'd0, '0, 1'b0);
        check("hold_rst", 3, 1'b1, 16'd2, 6'b0);

        // Level input held high across its ack re-pends without overrun
        drive(1'b0, 6'b000100, 1'b0, 2'd0, '0, 1'b0);
        drive(1'b0, 6'b000100, 1'b0, 2'd0, '0, 1'b1);
        drive(1'b0, 6'b000100, 1'b0, 2'd0, '0, 1'b0);
        drive(1'b0, 6'b000000, 1'b0, 2'd0, '0, 1'b0);
        check("lvl_hold", 0, 1'b1, 16'd2, 6'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
